// File: rtl/mixer_pkg.sv
// Shared types and constants for the time-multiplexed motor mixer.
// Coefficients are signed Q4.28; MIX_QUAD_X packs motor m, axis a at [(m*4+a)*32 +: 32].
package mixer_pkg;

    localparam int NUM_AXES      = 4;
    localparam int AXIS_THROTTLE = 0;
    localparam int AXIS_ROLL     = 1;
    localparam int AXIS_PITCH    = 2;
    localparam int AXIS_YAW      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        CLAMP = 2'd2,
        DONE  = 2'd3
    } mixer_state_t;

    localparam logic [31:0] COEF_POS = 32'h1000_0000;
    localparam logic [31:0] COEF_NEG = 32'hF000_0000;

    // Quad X, layout 3 ^ 1 / 2 0; each motor listed MSB-first as {yaw, pitch, roll, thr}
    localparam logic [511:0] MIX_QUAD_X = {
        COEF_NEG, COEF_POS, COEF_POS, COEF_POS,
        COEF_POS, COEF_NEG, COEF_POS, COEF_POS,
        COEF_POS, COEF_POS, COEF_NEG, COEF_POS,
        COEF_NEG, COEF_NEG, COEF_NEG, COEF_POS
    };

endpackage

// File: rtl/mixer_mac.sv
// Shared multiply / arithmetic-shift / accumulate datapath for the motor mixer.
// The shift floors toward -inf, so negative fractional products round down.
module mixer_mac #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 28,
    parameter int ACC_W     = DATA_W + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic signed [DATA_W-1:0] i_coef,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_coef_ext;
    logic signed [2*DATA_W-1:0] w_data_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [2*DATA_W-1:0] w_shift;
    logic signed [ACC_W-1:0]    w_term;
    logic signed [ACC_W-1:0]    r_acc;

    // Full-width signed product scaled back to integer units
    always_comb begin
        w_coef_ext = $signed({{DATA_W{i_coef[DATA_W-1]}}, i_coef});
        w_data_ext = $signed({{DATA_W{i_data[DATA_W-1]}}, i_data});
        w_prod     = w_coef_ext * w_data_ext;
        w_shift    = w_prod >>> FRAC_BITS;
        w_term     = w_shift[ACC_W-1:0];
    end

    // Accumulator: clear has priority over accumulate
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_term;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/motor_mixer_seq.sv
// Time-multiplexed motor mixer: one shared MAC evaluates every motor from a constant
// mix table, then clamps, applies the armed idle floor and publishes all motors at once.
module motor_mixer_seq import mixer_pkg::*; #(
    parameter int                              NUM_MOTORS = 4,
    parameter int                              DATA_W     = 32,
    parameter int                              FRAC_BITS  = 28,
    parameter logic [NUM_MOTORS*4*DATA_W-1:0]  MIX_TABLE  = MIX_QUAD_X,
    parameter int                              OUT_MIN    = 0,
    parameter int                              OUT_MAX    = 2000,
    parameter int                              IDLE       = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         armed,
    input  logic                         failsafe,
    input  logic signed [DATA_W-1:0]     in_throttle,
    input  logic signed [DATA_W-1:0]     in_roll,
    input  logic signed [DATA_W-1:0]     in_pitch,
    input  logic signed [DATA_W-1:0]     in_yaw,
    output logic [NUM_MOTORS*DATA_W-1:0] motor_out,
    output logic                         out_valid
);

    localparam int ACC_W = DATA_W + 3;
    localparam int MOT_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;

    localparam logic signed [ACC_W-1:0] ACC_MIN  = ACC_W'(OUT_MIN);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_IDLE = ACC_W'(IDLE);
    localparam logic [MOT_W-1:0]        LAST_MOTOR = MOT_W'(NUM_MOTORS - 1);

    // The IDLE parameter shadows the enum member, so the state is always named through the package
    mixer_state_t                r_state;
    logic [MOT_W-1:0]            r_motor;
    logic [1:0]                  r_axis;
    logic signed [DATA_W-1:0]    r_axis_in [NUM_AXES];
    logic                        r_armed;
    logic [NUM_MOTORS*DATA_W-1:0] r_shadow;
    logic [NUM_MOTORS*DATA_W-1:0] r_motor_out;
    logic                        r_out_valid;
    logic                        r_in_ready;

    int                          w_idx;
    logic signed [DATA_W-1:0]    w_coef;
    logic signed [DATA_W-1:0]    w_data;
    logic                        w_mac_en;
    logic                        w_mac_clr;
    logic signed [ACC_W-1:0]     w_acc;

    function automatic logic signed [DATA_W-1:0] clamp_motor(
        input logic signed [ACC_W-1:0] acc,
        input logic                    arm
    );
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] res;
        if (acc < ACC_MIN) begin
            v = ACC_MIN;
        end else if (acc > ACC_MAX) begin
            v = ACC_MAX;
        end else begin
            v = acc;
        end
        if (!arm) begin
            res = '0;
        end else if (v < ACC_IDLE) begin
            res = ACC_IDLE;
        end else begin
            res = v;
        end
        return res[DATA_W-1:0];
    endfunction

    // Coefficient / operand select and MAC control
    always_comb begin
        w_idx     = int'(r_motor) * NUM_AXES + int'(r_axis);
        w_coef    = MIX_TABLE[w_idx*DATA_W +: DATA_W];
        w_data    = r_axis_in[r_axis];
        w_mac_en  = (r_state == MAC) && !failsafe;
        w_mac_clr = (r_state == CLAMP) || failsafe;
    end

    mixer_mac #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_mac_en),
        .i_clr  (w_mac_clr),
        .i_coef (w_coef),
        .i_data (w_data),
        .o_acc  (w_acc)
    );

    // Sequencer: accept, 4 MAC cycles + 1 clamp per motor, then publish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= mixer_pkg::IDLE;
            r_motor     <= '0;
            r_axis      <= 2'd0;
            r_armed     <= 1'b0;
            r_shadow    <= '0;
            r_motor_out <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            for (int i = 0; i < NUM_AXES; i++) begin
                r_axis_in[i] <= '0;
            end
        end else if (failsafe) begin
            r_state     <= mixer_pkg::IDLE;
            r_motor     <= '0;
            r_axis      <= 2'd0;
            r_shadow    <= '0;
            r_motor_out <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                mixer_pkg::IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_axis_in[AXIS_THROTTLE] <= in_throttle;
                        r_axis_in[AXIS_ROLL]     <= in_roll;
                        r_axis_in[AXIS_PITCH]    <= in_pitch;
                        r_axis_in[AXIS_YAW]      <= in_yaw;
                        r_armed    <= armed;
                        r_motor    <= '0;
                        r_axis     <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= MAC;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                MAC: begin
                    if (r_axis == 2'd3) begin
                        r_axis  <= 2'd0;
                        r_state <= CLAMP;
                    end else begin
                        r_axis  <= r_axis + 2'd1;
                    end
                end
                CLAMP: begin
                    r_shadow[int'(r_motor)*DATA_W +: DATA_W] <= clamp_motor(w_acc, r_armed);
                    if (r_motor == LAST_MOTOR) begin
                        r_state <= DONE;
                    end else begin
                        r_motor <= r_motor + MOT_W'(1);
                        r_state <= MAC;
                    end
                end
                DONE: begin
                    r_motor_out <= r_shadow;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_motor     <= '0;
                    r_state     <= mixer_pkg::IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= mixer_pkg::IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign motor_out = r_motor_out;

endmodule

// File: tb/tb_motor_mixer_seq.sv
// Scoreboard bench for motor_mixer_seq: the driver queues hand-computed motor vectors,
// a negedge monitor pops them on out_valid and also checks latency and accept spacing.
module tb_motor_mixer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               in_valid;
    logic               armed;
    logic               failsafe;
    logic signed [31:0] thr, roll, pitch, yaw;
    logic               in_ready;
    logic               out_valid;
    logic [127:0]       motor_out;

    motor_mixer_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .armed       (armed),
        .failsafe    (failsafe),
        .in_throttle (thr),
        .in_roll     (roll),
        .in_pitch    (pitch),
        .in_yaw      (yaw),
        .motor_out   (motor_out),
        .out_valid   (out_valid)
    );

    // Single-motor instance with a -0.5 throttle coefficient to expose floor rounding
    localparam logic [127:0] NEG_HALF_TBL = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hF800_0000};
    logic               n_in_valid;
    logic               n_in_ready;
    logic               n_out_valid;
    logic signed [31:0] n_thr;
    logic [31:0]        n_motor_out;

    motor_mixer_seq #(
        .NUM_MOTORS (1),
        .MIX_TABLE  (NEG_HALF_TBL),
        .OUT_MIN    (-100),
        .OUT_MAX    (2000),
        .IDLE       (-100)
    ) dut_neg (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (n_in_valid),
        .in_ready    (n_in_ready),
        .armed       (1'b1),
        .failsafe    (1'b0),
        .in_throttle (n_thr),
        .in_roll     (32'sd0),
        .in_pitch    (32'sd0),
        .in_yaw      (32'sd0),
        .motor_out   (n_motor_out),
        .out_valid   (n_out_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_acc = 0;
    int prev_acc = -1;
    bit chk_gap  = 1'b0;
    logic [127:0] exp_q [$];
    int           acc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input int m0, input int m1, input int m2, input int m3);
        return {m3[31:0], m2[31:0], m1[31:0], m0[31:0]};
    endfunction

    // Monitor: track accepts, pop expected vectors on out_valid
    always @(negedge clk) begin
        if (reset || failsafe) begin
            acc_q.delete();
        end else if (in_valid && in_ready) begin
            n_acc++;
            if (chk_gap && prev_acc >= 0) check("accept_gap", cyc + 1 - prev_acc, 64'sd22);
            prev_acc = cyc + 1;
            acc_q.push_back(cyc + 1);
        end
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'sd1, 64'sd0);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                for (int m = 0; m < 4; m++) begin
                    check($sformatf("motor%0d", m), $signed(motor_out[m*32 +: 32]), $signed(e[m*32 +: 32]));
                end
                if (acc_q.size() == 0) check("latency_no_accept", 64'sd1, 64'sd0);
                else check("latency", cyc - acc_q.pop_front(), 64'sd21);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (n_acc < target && k < 100) begin
            tick();
            k++;
        end
        if (n_acc < target) check("accept_timeout", n_acc, target);
    endtask

    task automatic send(input int t, input int r, input int p, input int y, input bit arm);
        int start;
        start = n_acc;
        thr = t; roll = r; pitch = p; yaw = y; armed = arm;
        in_valid = 1'b1;
        wait_acc(start + 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 64'sd0);
        repeat (3) tick();
    endtask

    task automatic check_idle_zero(input string name);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s_motor%0d", name, m), $signed(motor_out[m*32 +: 32]), 64'sd0);
        end
        check({name, "_in_ready"}, in_ready, 64'sd1);
        check({name, "_out_valid"}, out_valid, 64'sd0);
    endtask

    task automatic neg_run(input int t, input int exp);
        int k = 0;
        n_thr = t;
        n_in_valid = 1'b1;
        tick();
        n_in_valid = 1'b0;
        while (n_out_valid !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check("neg_latency", k, 64'sd6);
        check("neg_value", $signed(n_motor_out), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; armed = 1'b0; failsafe = 1'b0;
        thr = 0; roll = 0; pitch = 0; yaw = 0;
        n_in_valid = 1'b0; n_thr = 0;
        repeat (3) tick();
        check_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Basic roll mix, clamp at OUT_MAX, idle floor, disarmed
        exp_q.push_back(pack4(900, 900, 1100, 1100));
        send(1000, 100, 0, 0, 1'b1);
        wait_drain(60);
        exp_q.push_back(pack4(1850, 2000, 1850, 2000));
        send(1950, 0, 100, 0, 1'b1);
        wait_drain(60);
        exp_q.push_back(pack4(0, 0, 0, 0));
        send(0, 100, 0, 0, 1'b0);
        wait_drain(60);
        exp_q.push_back(pack4(50, 50, 100, 100));
        send(0, 100, 0, 0, 1'b1);
        wait_drain(60);

        // Failsafe at cycle 7 after accept aborts without out_valid
        send(1000, 100, 0, 0, 1'b1);
        repeat (6) tick();
        failsafe = 1'b1;
        tick();
        failsafe = 1'b0;
        check_idle_zero("failsafe");
        repeat (30) tick();
        exp_q.push_back(pack4(480, 520, 520, 480));
        send(500, 0, 0, 20, 1'b1);
        wait_drain(60);

        // in_valid held: accepts every 22 cycles, mid-op input change ignored
        begin
            int start;
            chk_gap = 1'b1;
            prev_acc = -1;
            exp_q.push_back(pack4(900, 900, 1100, 1100));
            exp_q.push_back(pack4(1190, 1210, 1210, 1190));
            exp_q.push_back(pack4(1190, 1210, 1210, 1190));
            start = n_acc;
            thr = 1000; roll = 100; pitch = 0; yaw = 0; armed = 1'b1;
            in_valid = 1'b1;
            wait_acc(start + 1);
            repeat (5) tick();
            thr = 1200; roll = 0; yaw = 10;
            wait_acc(start + 3);
            in_valid = 1'b0;
            chk_gap = 1'b0;
            wait_drain(100);
        end

        // Reset at cycle 10 of a computation
        send(1000, 0, 0, 0, 1'b1);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("midreset");
        repeat (30) tick();

        // Floor rounding of negative products: -0.5*3 -> -2, -0.5*-3 -> 1, -0.5*7 -> -4
        neg_run(3, -2);
        tick();
        neg_run(-3, 1);
        tick();
        neg_run(7, -4);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
